// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding scoreboard.
// Entry fields are sized for the widest supported register file and pipeline.
package hazard_pkg;

  localparam int SB_RD_W  = 8;
  localparam int SB_STG_W = 8;
  localparam int CNT_W    = 32;
  localparam int FWD_RF   = 0;

  typedef struct packed {
    logic                valid;
    logic [SB_RD_W-1:0]  rd;
    logic [SB_STG_W-1:0] ready_stage;
  } sb_entry_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Compares one source register against every in-flight writer; the youngest
// (lowest stage) match decides whether the operand is forwardable or must stall.
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int REG_ADDR_W = 5,
  parameter int ZERO_REG   = 31,
  parameter int SEL_W      = $clog2(DEPTH + 1)
) (
  input  sb_entry_t [DEPTH-1:0]  entries_i,
  input  logic [REG_ADDR_W-1:0]  src_i,
  input  logic                   used_i,
  output logic                   hit_o,
  output logic                   ready_o,
  output logic [SEL_W-1:0]       sel_o
);

  logic             hit;
  logic             ready;
  logic [SEL_W-1:0] sel;

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    hit   = 1'b0;
    ready = 1'b0;
    sel   = SEL_W'(FWD_RF);
    if (used_i && (src_i != REG_ADDR_W'(ZERO_REG))) begin
      for (int k = DEPTH; k >= 1; k--) begin
        if (entries_i[k-1].valid && (entries_i[k-1].rd == SB_RD_W'(src_i))) begin
          hit   = 1'b1;
          ready = (k >= int'(entries_i[k-1].ready_stage));
          sel   = ready ? SEL_W'(k) : SEL_W'(FWD_RF);
        end
      end
    end
  end

  assign hit_o   = hit;
  assign ready_o = ready;
  assign sel_o   = sel;

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard of in-flight writers between Decode and ID->EX: selects forwarded
// operands, raises load-use stalls, squashes young entries on taken branches.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int REG_ADDR_W  = 5,
  parameter int ZERO_REG    = 31,
  parameter int DEPTH       = 3,
  parameter int LOAD_LAT    = 1,
  parameter int FLUSH_DEPTH = 2,
  parameter int SEL_W       = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    id_valid_i,
  input  logic [REG_ADDR_W-1:0]   id_rs1_i,
  input  logic [REG_ADDR_W-1:0]   id_rs2_i,
  input  logic                    id_rs1_used_i,
  input  logic                    id_rs2_used_i,
  input  logic [REG_ADDR_W-1:0]   id_rd_i,
  input  logic                    id_rd_we_i,
  input  logic                    id_is_load_i,
  input  logic                    hold_i,
  input  logic                    flush_i,
  input  logic [DATA_W-1:0]       rf_data_a_i,
  input  logic [DATA_W-1:0]       rf_data_b_i,
  input  logic [DEPTH*DATA_W-1:0] stage_data_i,
  output logic                    stall_o,
  output logic [SEL_W-1:0]        fwd_sel_a_o,
  output logic [SEL_W-1:0]        fwd_sel_b_o,
  output logic [DATA_W-1:0]       fwd_data_a_o,
  output logic [DATA_W-1:0]       fwd_data_b_o,
  output logic [CNT_W-1:0]        stall_count_o,
  output logic [CNT_W-1:0]        flush_count_o
);

  sb_entry_t [DEPTH-1:0] entries_q, entries_d;
  logic [CNT_W-1:0]      stall_count_q, stall_count_d;
  logic [CNT_W-1:0]      flush_count_q, flush_count_d;

  logic             hit_a, ready_a, hit_b, ready_b;
  logic [SEL_W-1:0] sel_a, sel_b;
  sb_entry_t        id_entry;

  hazard_src_match #(
    .DEPTH      (DEPTH),
    .REG_ADDR_W (REG_ADDR_W),
    .ZERO_REG   (ZERO_REG),
    .SEL_W      (SEL_W)
  ) u_match_a (
    .entries_i (entries_q),
    .src_i     (id_rs1_i),
    .used_i    (id_rs1_used_i),
    .hit_o     (hit_a),
    .ready_o   (ready_a),
    .sel_o     (sel_a)
  );

  hazard_src_match #(
    .DEPTH      (DEPTH),
    .REG_ADDR_W (REG_ADDR_W),
    .ZERO_REG   (ZERO_REG),
    .SEL_W      (SEL_W)
  ) u_match_b (
    .entries_i (entries_q),
    .src_i     (id_rs2_i),
    .used_i    (id_rs2_used_i),
    .hit_o     (hit_b),
    .ready_o   (ready_b),
    .sel_o     (sel_b)
  );

  // A squashed ID instruction must never stall the pipe.
  assign stall_o = id_valid_i && !flush_i &&
                   ((hit_a && !ready_a) || (hit_b && !ready_b));

  assign fwd_sel_a_o = sel_a;
  assign fwd_sel_b_o = sel_b;

  always_comb begin
    fwd_data_a_o = rf_data_a_i;
    fwd_data_b_o = rf_data_b_i;
    for (int k = 1; k <= DEPTH; k++) begin
      if (sel_a == SEL_W'(k)) fwd_data_a_o = stage_data_i[(k-1)*DATA_W +: DATA_W];
      if (sel_b == SEL_W'(k)) fwd_data_b_o = stage_data_i[(k-1)*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    id_entry.valid       = id_valid_i && id_rd_we_i && (id_rd_i != REG_ADDR_W'(ZERO_REG));
    id_entry.rd          = SB_RD_W'(id_rd_i);
    id_entry.ready_stage = id_is_load_i ? SB_STG_W'(1 + LOAD_LAT) : SB_STG_W'(1);
  end

  always_comb begin
    entries_d     = entries_q;
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (hold_i) begin
      entries_d = entries_q;
    end else if (flush_i) begin
      // Writers beyond the branch stage survive; everything younger is squashed.
      for (int k = FLUSH_DEPTH; k < DEPTH; k++) entries_d[k] = entries_q[k-1];
      for (int k = 0; k < FLUSH_DEPTH; k++) entries_d[k] = '0;
      flush_count_d = sat_inc(flush_count_q);
    end else begin
      for (int k = 1; k < DEPTH; k++) entries_d[k] = entries_q[k-1];
      if (stall_o) begin
        entries_d[0]  = '0;
        stall_count_d = sat_inc(stall_count_q);
      end else begin
        entries_d[0] = id_entry;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entries_q     <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      entries_q     <= entries_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count_o = stall_count_q;
  assign flush_count_o = flush_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Vector table plus expectation queue for the hazard scoreboard; a second
// instance with DEPTH=5/LOAD_LAT=2 covers the longer load-use window.
module tb_hazard_scoreboard;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid, rs1_used, rs2_used, rd_we, is_load, hold, flush;
  logic [4:0]    rs1, rs2, rd;
  logic [DW-1:0] rf_a, rf_b;
  logic [3*DW-1:0] sd1;
  logic [5*DW-1:0] sd2;

  logic          stall1, stall2;
  logic [1:0]    sa1, sb1;
  logic [2:0]    sa2, sb2;
  logic [DW-1:0] da1, db1, da2, db2;
  logic [31:0]   sc1, fc1, sc2, fc2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .id_valid_i(id_valid),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
    .id_rd_i(rd), .id_rd_we_i(rd_we), .id_is_load_i(is_load),
    .hold_i(hold), .flush_i(flush), .rf_data_a_i(rf_a), .rf_data_b_i(rf_b),
    .stage_data_i(sd1), .stall_o(stall1), .fwd_sel_a_o(sa1), .fwd_sel_b_o(sb1),
    .fwd_data_a_o(da1), .fwd_data_b_o(db1), .stall_count_o(sc1), .flush_count_o(fc1)
  );

  hazard_scoreboard #(.DEPTH(5), .LOAD_LAT(2)) dut5 (
    .clk(clk), .reset(reset), .id_valid_i(id_valid),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
    .id_rd_i(rd), .id_rd_we_i(rd_we), .id_is_load_i(is_load),
    .hold_i(hold), .flush_i(flush), .rf_data_a_i(rf_a), .rf_data_b_i(rf_b),
    .stage_data_i(sd2), .stall_o(stall2), .fwd_sel_a_o(sa2), .fwd_sel_b_o(sb2),
    .fwd_data_a_o(da2), .fwd_data_b_o(db2), .stall_count_o(sc2), .flush_count_o(fc2)
  );

  typedef struct {
    logic       vld;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       we, ld, hold, flush;
    logic       stall;
    logic [2:0] sa, sb;
    logic       dc;
    int         sc, fc;
  } vec_t;

  typedef struct {
    logic          stall;
    logic [2:0]    sa, sb;
    logic [DW-1:0] da, db;
    logic          dc;
    logic [31:0]   sc, fc;
  } exp_t;

  exp_t exp_q[$];
  vec_t vt[22];

  function automatic vec_t mk(input logic vld, input logic [4:0] r1, input logic u1,
                              input logic [4:0] r2, input logic u2, input logic [4:0] d,
                              input logic we, input logic ld, input logic hd, input logic fl,
                              input logic st, input logic [2:0] sa, input logic [2:0] sb,
                              input logic dc, input int sc, input int fc);
    vec_t v;
    v.vld = vld; v.rs1 = r1; v.u1 = u1; v.rs2 = r2; v.u2 = u2; v.rd = d;
    v.we = we; v.ld = ld; v.hold = hd; v.flush = fl;
    v.stall = st; v.sa = sa; v.sb = sb; v.dc = dc; v.sc = sc; v.fc = fc;
    return v;
  endfunction

  // Stage k carries base+k on its data slice.
  function automatic logic [DW-1:0] exp_data(input logic [2:0] sel, input logic [DW-1:0] rf,
                                             input logic [DW-1:0] base);
    return (sel == 3'd0) ? rf : base + DW'(sel);
  endfunction

  task automatic drive(input vec_t v);
    id_valid = v.vld; rs1 = v.rs1; rs1_used = v.u1; rs2 = v.rs2; rs2_used = v.u2;
    rd = v.rd; rd_we = v.we; is_load = v.ld; hold = v.hold; flush = v.flush;
  endtask

  task automatic push(input vec_t v, input logic [DW-1:0] base);
    exp_t e;
    e.stall = v.stall; e.sa = v.sa; e.sb = v.sb; e.dc = v.dc;
    e.da = exp_data(v.sa, rf_a, base);
    e.db = exp_data(v.sb, rf_b, base);
    e.sc = 32'(v.sc); e.fc = 32'(v.fc);
    exp_q.push_back(e);
  endtask

  task automatic cmp(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check(input string tag, input bit use5);
    exp_t e;
    logic st;
    logic [2:0] sa, sb;
    logic [DW-1:0] da, db;
    logic [31:0] sc, fc;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: expectation queue empty", tag);
      return;
    end
    e = exp_q.pop_front();
    if (use5) begin
      st = stall2; sa = sa2; sb = sb2; da = da2; db = db2; sc = sc2; fc = fc2;
    end else begin
      st = stall1; sa = {1'b0, sa1}; sb = {1'b0, sb1}; da = da1; db = db1; sc = sc1; fc = fc1;
    end
    cmp({tag, ".stall"}, DW'(st), DW'(e.stall));
    cmp({tag, ".sel_a"}, DW'(sa), DW'(e.sa));
    cmp({tag, ".sel_b"}, DW'(sb), DW'(e.sb));
    if (!e.dc) begin
      cmp({tag, ".data_a"}, da, e.da);
      cmp({tag, ".data_b"}, db, e.db);
    end
    cmp({tag, ".stall_cnt"}, DW'(sc), DW'(e.sc));
    cmp({tag, ".flush_cnt"}, DW'(fc), DW'(e.fc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //            vld rs1 u1 rs2 u2 rd we ld hd fl  st sa sb dc sc fc
    vt[0]  = mk(1,  2, 1,  3, 1,  1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    vt[1]  = mk(1,  1, 1,  3, 1,  2, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0);
    vt[2]  = mk(1,  5, 1,  0, 0,  4, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0);
    vt[3]  = mk(1,  4, 1,  4, 1,  5, 1, 0, 0, 0,  1, 0, 0, 1, 0, 0);
    vt[4]  = mk(1,  4, 1,  4, 1,  5, 1, 0, 0, 0,  0, 2, 2, 0, 1, 0);
    vt[5]  = mk(1,  5, 1,  4, 1,  6, 1, 0, 0, 0,  0, 1, 3, 0, 1, 0);
    vt[6]  = mk(1,  2, 1,  3, 1,  1, 1, 0, 0, 0,  0, 0, 0, 0, 1, 0);
    vt[7]  = mk(1,  6, 1,  5, 1,  1, 1, 0, 0, 0,  0, 2, 3, 0, 1, 0);
    vt[8]  = mk(1,  1, 1,  1, 1, 31, 1, 0, 0, 0,  0, 1, 1, 0, 1, 0);
    vt[9]  = mk(1, 31, 1, 31, 1,  7, 1, 0, 0, 0,  0, 0, 0, 0, 1, 0);
    vt[10] = mk(1,  7, 0,  1, 1,  8, 1, 1, 0, 0,  0, 0, 3, 0, 1, 0);
    vt[11] = mk(1,  8, 1,  7, 1,  9, 1, 0, 0, 1,  0, 0, 2, 1, 1, 0);
    vt[12] = mk(1,  7, 1,  8, 1,  9, 0, 0, 0, 0,  0, 3, 0, 0, 1, 1);
    vt[13] = mk(1,  2, 1,  3, 0,  4, 1, 1, 0, 0,  0, 0, 0, 0, 1, 1);
    vt[14] = mk(1,  4, 1,  4, 1,  5, 1, 0, 1, 0,  1, 0, 0, 1, 1, 1);
    vt[15] = mk(1,  4, 1,  4, 1,  5, 1, 0, 1, 0,  1, 0, 0, 1, 1, 1);
    vt[16] = mk(1,  4, 1,  4, 1,  5, 1, 0, 1, 0,  1, 0, 0, 1, 1, 1);
    vt[17] = mk(1,  4, 1,  4, 1,  5, 1, 0, 0, 0,  1, 0, 0, 1, 1, 1);
    vt[18] = mk(1,  4, 1,  4, 1,  5, 1, 0, 0, 0,  0, 2, 2, 0, 2, 1);
    vt[19] = mk(1,  2, 1,  3, 1, 10, 1, 1, 0, 0,  0, 0, 0, 0, 2, 1);
    vt[20] = mk(0, 10, 1,  5, 1, 12, 1, 0, 0, 0,  0, 0, 2, 1, 2, 1);
    vt[21] = mk(1, 10, 1,  5, 1, 11, 1, 0, 0, 0,  0, 2, 3, 0, 2, 1);

    rf_a = 64'hAAAA_0000_0000_AAAA;
    rf_b = 64'hBBBB_0000_0000_BBBB;
    sd1  = {64'h7, 64'h6, 64'h5};
    for (int k = 0; k < 5; k++) sd2[k*DW +: DW] = 64'h20 + DW'(k + 1);

    reset = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #12;
    push(mk(0, 1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 64'h4);
    check("reset", 1'b0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      @(posedge clk);
      #1;
      drive(vt[i]);
      push(vt[i], 64'h4);
      @(negedge clk);
      check($sformatf("vec%0d", i), 1'b0);
    end

    // Asynchronous reset mid-cycle with live forwarding paths.
    @(posedge clk);
    #1;
    v = mk(1, 11, 1, 10, 1, 12, 1, 0, 0, 0, 0, 1, 3, 0, 2, 1);
    drive(v);
    push(v, 64'h4);
    #2;
    check("pre_reset", 1'b0);
    reset = 1'b1;
    #1;
    push(mk(1, 11, 1, 10, 1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 64'h4);
    check("async_reset", 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Deep pipeline: load-use costs two bubbles before stage-3 forwarding.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) v = mk(1, 2, 1, 3, 1, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      else if (i == 3) v = mk(1, 4, 1, 4, 1, 5, 1, 0, 0, 0, 0, 3, 3, 0, 2, 0);
      else v = mk(1, 4, 1, 4, 1, 5, 1, 0, 0, 0, 1, 0, 0, 1, i - 1, 0);
      drive(v);
      push(v, 64'h20);
      @(negedge clk);
      check($sformatf("deep%0d", i), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
